// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
// Bundles every non-clock signal between the pipeline datapath and the
// hazard/stall controller.
//   master : pipeline side. Drives the decode/execute operand info, cache busy
//            flags and perf_clr. Receives the register enables, flushes,
//            fetch_valid, the FSM state and the performance counters.
//   slave  : hazard_ctrl side (directions are the mirror image of master).
// Parameters:
//   REG_ADDR_WIDTH : register index width
//   CNT_WIDTH      : performance counter width
// ---------------------------------------------------------------------------
interface hazard_ctrl_if #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
);
    logic                      valid_d;
    logic [REG_ADDR_WIDTH-1:0] rs1_d;
    logic [REG_ADDR_WIDTH-1:0] rs2_d;
    logic                      uses_rs1_d;
    logic                      uses_rs2_d;
    logic                      valid_e;
    logic [REG_ADDR_WIDTH-1:0] rd_e;
    logic                      load_e;
    logic                      redirect_e;
    logic                      imiss;
    logic                      dmiss;
    logic                      perf_clr;

    logic                      en_pc;
    logic                      en_d;
    logic                      en_e;
    logic                      en_m;
    logic                      flush_d_n;
    logic                      flush_e_n;
    logic                      fetch_valid;
    logic [1:0]                state;
    logic [CNT_WIDTH-1:0]      stall_cnt;
    logic [CNT_WIDTH-1:0]      flush_cnt;

    modport master (
        output valid_d, rs1_d, rs2_d, uses_rs1_d, uses_rs2_d,
        output valid_e, rd_e, load_e, redirect_e,
        output imiss, dmiss, perf_clr,
        input  en_pc, en_d, en_e, en_m, flush_d_n, flush_e_n, fetch_valid,
        input  state, stall_cnt, flush_cnt
    );

    modport slave (
        input  valid_d, rs1_d, rs2_d, uses_rs1_d, uses_rs2_d,
        input  valid_e, rd_e, load_e, redirect_e,
        input  imiss, dmiss, perf_clr,
        output en_pc, en_d, en_e, en_m, flush_d_n, flush_e_n, fetch_valid,
        output state, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard and stall controller for the cache-equipped 5-stage core.
// Each cycle it decides whether the PC, fetch/decode, decode/execute and
// execute/memory registers advance, hold or are flushed, based on a load-use
// check, taken redirects in execute and the I/D-cache busy flags. It also
// remembers a redirect that arrived during an I-cache miss so the stale
// instruction returned by that miss is dropped, and keeps saturating
// stall/flush counters.
// Ports:
//   clk : clock
//   rst : asynchronous, active-high reset
//   bus : hazard_ctrl_if.slave
//         inputs  valid_d, rs1_d, rs2_d, uses_rs1_d, uses_rs2_d, valid_e,
//                 rd_e, load_e, redirect_e, imiss, dmiss, perf_clr
//         outputs en_pc, en_d, en_e, en_m (1 = advance), flush_d_n,
//                 flush_e_n (active-low flush), fetch_valid, state,
//                 stall_cnt, flush_cnt
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        DSTALL    = 2'd1,
        LU_BUBBLE = 2'd2,
        IWAIT     = 2'd3
    } state_t;

    state_t                    state_q;
    state_t                    state_d;
    logic                      squashPending_q;
    logic                      squashPending_d;
    logic [CNT_WIDTH-1:0]      stallCnt_q;
    logic [CNT_WIDTH-1:0]      stallCnt_d;
    logic [CNT_WIDTH-1:0]      flushCnt_q;
    logic [CNT_WIDTH-1:0]      flushCnt_d;

    logic [REG_ADDR_WIDTH-1:0] rs1D;
    logic [REG_ADDR_WIDTH-1:0] rs2D;
    logic [REG_ADDR_WIDTH-1:0] rdE;
    logic                      rs1Hit;
    logic                      rs2Hit;
    logic                      loadUse;
    logic                      redirectTaken;

    logic                      enPc;
    logic                      enD;
    logic                      enE;
    logic                      enM;
    logic                      flushDN;
    logic                      flushEN;
    logic                      fetchValid;
    logic                      flushInc;

    assign rs1D = bus.rs1_d;
    assign rs2D = bus.rs2_d;
    assign rdE  = bus.rd_e;

    // Load-use detection: a load in execute whose nonzero destination is read
    // by the real instruction in decode. x0 is never a dependency because it
    // always reads as zero regardless of what the load writes.
    always_comb begin
        rs1Hit        = bus.uses_rs1_d && (rs1D == rdE);
        rs2Hit        = bus.uses_rs2_d && (rs2D == rdE);
        loadUse       = bus.valid_e && bus.load_e && (rdE != '0) &&
                        bus.valid_d && (rs1Hit || rs2Hit);
        redirectTaken = bus.redirect_e && bus.valid_e;
    end

    // Control decision and next-state logic. The rules are evaluated in strict
    // priority order: a D-cache miss freezes everything (a pending redirect
    // simply waits in the frozen execute stage), then a taken redirect, then
    // the load-use bubble, then the I-cache miss bubble, else normal flow.
    // The squash flag is only cleared on a cycle where fetch data is really
    // returned (imiss = 0) and consumed, so the stale miss result is dropped
    // exactly once. While reset is held every control output is forced low.
    always_comb begin
        enPc            = 1'b1;
        enD             = 1'b1;
        enE             = 1'b1;
        enM             = 1'b1;
        flushDN         = 1'b1;
        flushEN         = 1'b1;
        fetchValid      = 1'b0;
        flushInc        = 1'b0;
        state_d         = RUN;
        squashPending_d = squashPending_q;

        if (rst) begin
            enPc    = 1'b0;
            enD     = 1'b0;
            enE     = 1'b0;
            enM     = 1'b0;
            flushDN = 1'b0;
            flushEN = 1'b0;
            state_d = RUN;
        end else if (bus.dmiss) begin
            enPc    = 1'b0;
            enD     = 1'b0;
            enE     = 1'b0;
            enM     = 1'b0;
            state_d = DSTALL;
        end else if (redirectTaken) begin
            flushDN         = 1'b0;
            flushEN         = 1'b0;
            flushInc        = 1'b1;
            squashPending_d = bus.imiss;
            state_d         = bus.imiss ? IWAIT : RUN;
        end else if (loadUse) begin
            enPc    = 1'b0;
            enD     = 1'b0;
            flushEN = 1'b0;
            state_d = LU_BUBBLE;
        end else if (bus.imiss) begin
            enPc    = 1'b0;
            state_d = IWAIT;
        end else begin
            fetchValid      = ~squashPending_q;
            squashPending_d = 1'b0;
            state_d         = RUN;
        end
    end

    // FSM state and squash flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= RUN;
            squashPending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            squashPending_q <= squashPending_d;
        end
    end

    // Performance counter next values. A clear wins over an increment in the
    // same cycle, and both counters stick at all-ones instead of wrapping so
    // a long run never reports a misleadingly small number.
    always_comb begin
        stallCnt_d = stallCnt_q;
        flushCnt_d = flushCnt_q;
        if (bus.perf_clr) begin
            stallCnt_d = '0;
            flushCnt_d = '0;
        end else begin
            if (!enPc && (stallCnt_q != '1)) begin
                stallCnt_d = stallCnt_q + 1'b1;
            end
            if (flushInc && (flushCnt_q != '1)) begin
                flushCnt_d = flushCnt_q + 1'b1;
            end
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCnt_q <= '0;
            flushCnt_q <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
            flushCnt_q <= flushCnt_d;
        end
    end

    assign bus.en_pc       = enPc;
    assign bus.en_d        = enD;
    assign bus.en_e        = enE;
    assign bus.en_m        = enM;
    assign bus.flush_d_n   = flushDN;
    assign bus.flush_e_n   = flushEN;
    assign bus.fetch_valid = fetchValid;
    assign bus.state       = state_q;
    assign bus.stall_cnt   = stallCnt_q;
    assign bus.flush_cnt   = flushCnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Self-checking bench for hazard_ctrl. Directed scenarios plus a randomized
// run compared against a rule-level reference model. A narrow counter width
// keeps the saturation scenario short.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int RW   = 5;
    localparam int CW   = 6;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;

    // reference model state
    int mState;
    bit mSquash;
    int mStall;
    int mFlush;

    hazard_ctrl_if #(.REG_ADDR_WIDTH(RW), .CNT_WIDTH(CW)) bus ();

    hazard_ctrl #(.REG_ADDR_WIDTH(RW), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Which rule applies right now: 0 reset, 1 dmiss, 2 redirect,
    // 3 load-use, 4 imiss, 5 normal.
    function automatic int ruleNow();
        bit readsLoad;
        if (rst) return 0;
        if (bus.dmiss) return 1;
        if (bus.redirect_e && bus.valid_e) return 2;
        readsLoad = (bus.uses_rs1_d && bus.rs1_d == bus.rd_e) ||
                    (bus.uses_rs2_d && bus.rs2_d == bus.rd_e);
        if (bus.valid_e && bus.load_e && bus.rd_e != '0 && bus.valid_d && readsLoad) return 3;
        if (bus.imiss) return 4;
        return 5;
    endfunction

    // Expected {en_pc,en_d,en_e,en_m,flush_d_n,flush_e_n,fetch_valid}
    function automatic logic [6:0] expOut(int r);
        case (r)
            0:       return 7'b0000000;
            1:       return 7'b0000110;
            2:       return 7'b1111000;
            3:       return 7'b0011100;
            4:       return 7'b0111110;
            default: return {6'b111111, ~mSquash};
        endcase
    endfunction

    // fetch_valid is don't-care while decode is held by a load-use bubble
    function automatic logic [6:0] expMask(int r);
        return (r == 3) ? 7'b1111110 : 7'b1111111;
    endfunction

    function automatic logic [6:0] actOut();
        return {bus.en_pc, bus.en_d, bus.en_e, bus.en_m,
                bus.flush_d_n, bus.flush_e_n, bus.fetch_valid};
    endfunction

    task automatic modelReset();
        mState  = 0;
        mSquash = 1'b0;
        mStall  = 0;
        mFlush  = 0;
    endtask

    task automatic modelAdvance();
        int r;
        r = ruleNow();
        if (r == 0) return;
        if (bus.perf_clr) begin
            mStall = 0;
            mFlush = 0;
        end else begin
            if ((r == 1 || r == 3 || r == 4) && mStall < CMAX) mStall++;
            if (r == 2 && mFlush < CMAX) mFlush++;
        end
        case (r)
            1: mState = 1;
            2: begin
                mState  = bus.imiss ? 3 : 0;
                mSquash = bus.imiss;
            end
            3: mState = 2;
            4: mState = 3;
            default: begin
                mState  = 0;
                mSquash = 1'b0;
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        modelAdvance();
        #1;
    endtask

    task automatic applyStimulus(input logic vd, input logic [RW-1:0] r1, input logic [RW-1:0] r2,
                                 input logic u1, input logic u2, input logic ve,
                                 input logic [RW-1:0] rde, input logic ld, input logic rdr,
                                 input logic im, input logic dm, input logic pc);
        bus.valid_d    = vd;
        bus.rs1_d      = r1;
        bus.rs2_d      = r2;
        bus.uses_rs1_d = u1;
        bus.uses_rs2_d = u2;
        bus.valid_e    = ve;
        bus.rd_e       = rde;
        bus.load_e     = ld;
        bus.redirect_e = rdr;
        bus.imiss      = im;
        bus.dmiss      = dm;
        bus.perf_clr   = pc;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        #2;
        checks++;
        if (actOut() !== 7'b0000000) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %b want %b", actOut(), 7'b0000000);
        end
        checks++;
        if (bus.state !== 2'd0 || bus.stall_cnt !== '0 || bus.flush_cnt !== '0) begin
            errors++;
            $display("[TB] FAIL reset_regs got state=%0d stall=%0d flush=%0d want 0/0/0",
                     bus.state, bus.stall_cnt, bus.flush_cnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        #2;
        checks++;
        if (actOut() !== 7'b1111111) begin
            errors++;
            $display("[TB] FAIL post_reset_run got %b want %b", actOut(), 7'b1111111);
        end
        tick();
    endtask

    task automatic test_load_use();
        doReset();
        applyStimulus(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        checks++;
        if ((actOut() & 7'b1111110) !== 7'b0011100) begin
            errors++;
            $display("[TB] FAIL load_use_rs2 got %b want 001110x", actOut());
        end
        tick();
        checks++;
        if (bus.state !== 2'd2 || bus.stall_cnt !== 6'd1) begin
            errors++;
            $display("[TB] FAIL load_use_regs got state=%0d stall=%0d want 2/1", bus.state, bus.stall_cnt);
        end
        applyStimulus(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        checks++;
        if (actOut() !== 7'b1111111) begin
            errors++;
            $display("[TB] FAIL load_use_release got %b want %b", actOut(), 7'b1111111);
        end
        tick();
        checks++;
        if (bus.state !== 2'd0 || bus.stall_cnt !== 6'd1) begin
            errors++;
            $display("[TB] FAIL load_use_after got state=%0d stall=%0d want 0/1", bus.state, bus.stall_cnt);
        end
        applyStimulus(1'b1, 5'd7, 5'd9, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        checks++;
        if ((actOut() & 7'b1111110) !== 7'b0011100) begin
            errors++;
            $display("[TB] FAIL load_use_rs1 got %b want 001110x", actOut());
        end
        tick();
        applyStimulus(1'b1, 5'd7, 5'd9, 1'b0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        checks++;
        if (actOut() !== 7'b1111111) begin
            errors++;
            $display("[TB] FAIL load_use_unread_rs1 got %b want %b", actOut(), 7'b1111111);
        end
        tick();
    endtask

    task automatic test_rd_zero();
        doReset();
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        checks++;
        if (actOut() !== 7'b1111111) begin
            errors++;
            $display("[TB] FAIL rd_zero got %b want %b", actOut(), 7'b1111111);
        end
        tick();
        checks++;
        if (bus.state !== 2'd0 || bus.stall_cnt !== 6'd0) begin
            errors++;
            $display("[TB] FAIL rd_zero_regs got state=%0d stall=%0d want 0/0", bus.state, bus.stall_cnt);
        end
    endtask

    task automatic test_dmiss_redirect();
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            #2;
            checks++;
            if (actOut() !== 7'b0000110) begin
                errors++;
                $display("[TB] FAIL dmiss_freeze[%0d] got %b want %b", i, actOut(), 7'b0000110);
            end
            tick();
        end
        checks++;
        if (bus.state !== 2'd1 || bus.stall_cnt !== 6'd4 || bus.flush_cnt !== 6'd0) begin
            errors++;
            $display("[TB] FAIL dmiss_regs got state=%0d stall=%0d flush=%0d want 1/4/0",
                     bus.state, bus.stall_cnt, bus.flush_cnt);
        end
        applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        checks++;
        if (actOut() !== 7'b1111000) begin
            errors++;
            $display("[TB] FAIL dmiss_then_redirect got %b want %b", actOut(), 7'b1111000);
        end
        tick();
        checks++;
        if (bus.state !== 2'd0 || bus.flush_cnt !== 6'd1 || bus.stall_cnt !== 6'd4) begin
            errors++;
            $display("[TB] FAIL redirect_regs got state=%0d stall=%0d flush=%0d want 0/4/1",
                     bus.state, bus.stall_cnt, bus.flush_cnt);
        end
    endtask

    task automatic test_redirect_imiss();
        doReset();
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        checks++;
        if (actOut() !== 7'b1111000) begin
            errors++;
            $display("[TB] FAIL redirect_in_miss got %b want %b", actOut(), 7'b1111000);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            #2;
            checks++;
            if (actOut() !== 7'b0111110 || bus.state !== 2'd3) begin
                errors++;
                $display("[TB] FAIL imiss_wait[%0d] got %b state=%0d want %b state=3",
                         i, actOut(), bus.state, 7'b0111110);
            end
            tick();
        end
        idle();
        #2;
        checks++;
        if (actOut() !== 7'b1111110) begin
            errors++;
            $display("[TB] FAIL squash_drop got %b want %b", actOut(), 7'b1111110);
        end
        tick();
        #2;
        checks++;
        if (actOut() !== 7'b1111111) begin
            errors++;
            $display("[TB] FAIL squash_done got %b want %b", actOut(), 7'b1111111);
        end
        tick();
        checks++;
        if (bus.stall_cnt !== 6'd3 || bus.flush_cnt !== 6'd1) begin
            errors++;
            $display("[TB] FAIL imiss_counts got stall=%0d flush=%0d want 3/1", bus.stall_cnt, bus.flush_cnt);
        end
    endtask

    task automatic test_priority();
        doReset();
        applyStimulus(1'b1, 5'd6, 5'd6, 1'b1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        #2;
        checks++;
        if (actOut() !== 7'b0000110) begin
            errors++;
            $display("[TB] FAIL priority_dmiss got %b want %b", actOut(), 7'b0000110);
        end
        tick();
        checks++;
        if (bus.state !== 2'd1 || bus.flush_cnt !== 6'd0 || bus.stall_cnt !== 6'd1) begin
            errors++;
            $display("[TB] FAIL priority_regs got state=%0d stall=%0d flush=%0d want 1/1/0",
                     bus.state, bus.stall_cnt, bus.flush_cnt);
        end
    endtask

    task automatic test_saturation();
        doReset();
        for (int i = 0; i < CMAX + 5; i++) begin
            applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            tick();
        end
        checks++;
        if (bus.stall_cnt !== 6'(CMAX)) begin
            errors++;
            $display("[TB] FAIL stall_saturate got %0d want %0d", bus.stall_cnt, CMAX);
        end
        tick();
        checks++;
        if (bus.stall_cnt !== 6'(CMAX)) begin
            errors++;
            $display("[TB] FAIL stall_hold got %0d want %0d", bus.stall_cnt, CMAX);
        end
        for (int i = 0; i < CMAX + 3; i++) begin
            applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        checks++;
        if (bus.flush_cnt !== 6'(CMAX)) begin
            errors++;
            $display("[TB] FAIL flush_saturate got %0d want %0d", bus.flush_cnt, CMAX);
        end
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        checks++;
        if (bus.stall_cnt !== 6'd0 || bus.flush_cnt !== 6'd0) begin
            errors++;
            $display("[TB] FAIL perf_clr got stall=%0d flush=%0d want 0/0", bus.stall_cnt, bus.flush_cnt);
        end
    endtask

    task automatic test_reset_mid_miss();
        doReset();
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (actOut() !== 7'b0000000 || bus.state !== 2'd0 || bus.flush_cnt !== 6'd0) begin
            errors++;
            $display("[TB] FAIL async_reset got %b state=%0d flush=%0d want 0000000 state=0 flush=0",
                     actOut(), bus.state, bus.flush_cnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        idle();
        #2;
        checks++;
        if (actOut() !== 7'b1111111) begin
            errors++;
            $display("[TB] FAIL squash_cleared_by_reset got %b want %b", actOut(), 7'b1111111);
        end
        tick();
    endtask

    task automatic test_random();
        int r;
        doReset();
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0),
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0),
                          1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
                          1'($urandom_range(0, 31) == 0));
            #2;
            r = ruleNow();
            checks++;
            if ((actOut() & expMask(r)) !== (expOut(r) & expMask(r))) begin
                errors++;
                $display("[TB] FAIL rand_ctrl[%0d] rule=%0d got %b want %b", i, r, actOut(), expOut(r));
            end
            tick();
            checks++;
            if (bus.state !== 2'(mState) || bus.stall_cnt !== 6'(mStall) || bus.flush_cnt !== 6'(mFlush)) begin
                errors++;
                $display("[TB] FAIL rand_regs[%0d] got state=%0d stall=%0d flush=%0d want %0d/%0d/%0d",
                         i, bus.state, bus.stall_cnt, bus.flush_cnt, mState, mStall, mFlush);
            end
        end
    endtask

    initial begin
        modelReset();
        test_reset();
        test_load_use();
        test_rd_zero();
        test_dmiss_redirect();
        test_redirect_imiss();
        test_priority();
        test_saturation();
        test_reset_mid_miss();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
